// File: rtl/cfa_pkg.sv
// Shared types and helpers for the CFA tap-window slice.
package cfa_pkg;

    localparam int unsigned PIX_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    // Five taps centred on one pixel; also used by the green_h_v wrapper.
    typedef struct packed {
        logic [PIX_W_DEF-1:0] m2;
        logic [PIX_W_DEF-1:0] m1;
        logic [PIX_W_DEF-1:0] c;
        logic [PIX_W_DEF-1:0] p1;
        logic [PIX_W_DEF-1:0] p2;
    } tap5_t;

    // clog2 with a floor of one bit so single-value ranges still get a port.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cfa_line_buffer.sv
// Single-port line memory: read-first, registered read, holds when disabled.
module cfa_line_buffer #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned PIX_W = 12,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             enable,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Old word goes out, new word goes in, on every enabled edge.
    always_ff @(posedge clk) begin
        if (enable) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/cfa_tap_window.sv
// 5x5 neighbourhood tap extractor: vertical and horizontal 5-tap vectors
// around each interior pixel of a raster Bayer stream.
module cfa_tap_window
    import cfa_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    localparam int unsigned RW   = clog2_min1(IMG_H),
    localparam int unsigned CW   = clog2_min1(IMG_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] v_m2,
    output logic [PIX_W-1:0] v_m1,
    output logic [PIX_W-1:0] v_c,
    output logic [PIX_W-1:0] v_p1,
    output logic [PIX_W-1:0] v_p2,
    output logic [PIX_W-1:0] h_m2,
    output logic [PIX_W-1:0] h_m1,
    output logic [PIX_W-1:0] h_c,
    output logic [PIX_W-1:0] h_p1,
    output logic [PIX_W-1:0] h_p2,
    output logic             out_valid,
    output logic [RW-1:0]    cen_row,
    output logic [CW-1:0]    cen_col,
    output logic [1:0]       cen_phase
);

    state_t          state, state_nx;
    logic [RW-1:0]   row, row_nx, r_cur;
    logic [CW-1:0]   col, col_nx, x_cur;
    state_t          st_cur;
    logic            acc, qual;
    logic [CW-1:0]   aux_addr;
    logic [PIX_W-1:0] rd [4];
    logic [PIX_W-1:0] pix_q;
    logic [4:0][PIX_W-1:0] col_vec, col_a, col_b, h_vec, s2_v, s2_h, out_v, out_h;
    logic [3:0][PIX_W-1:0] hsh;
    logic            s1_valid, s2_valid;
    logic [RW-1:0]   s1_cr, s2_cr;
    logic [CW-1:0]   s1_cc, s2_cc;

    // Position/state of the pixel on the inputs (sof overrides) and next-state logic.
    always_comb begin
        st_cur   = sof ? FILL : state;
        r_cur    = sof ? '0 : row;
        x_cur    = sof ? '0 : col;
        acc      = pix_valid && (sof || (state != IDLE));
        qual     = acc && (st_cur == RUN) && (x_cur >= CW'(4));
        state_nx = state;
        row_nx   = row;
        col_nx   = col;
        if (acc) begin
            if (x_cur == CW'(IMG_W - 1)) begin
                col_nx = '0;
                row_nx = r_cur + RW'(1);
            end else begin
                col_nx = x_cur + CW'(1);
                row_nx = r_cur;
            end
            case (st_cur)
                FILL: state_nx = (x_cur == CW'(IMG_W - 1) && r_cur == RW'(3)) ? RUN : FILL;
                RUN: begin
                    if (x_cur == CW'(IMG_W - 1) && r_cur == RW'(IMG_H - 1)) begin
                        state_nx = IDLE;
                        row_nx   = '0;
                        col_nx   = '0;
                    end else begin
                        state_nx = RUN;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // FSM and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_nx;
            row   <= row_nx;
            col   <= col_nx;
        end
    end

    // Stages 1..3 are one word short and see their input one accept late,
    // so together each still delays by exactly IMG_W accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            aux_addr <= '0;
        end else if (acc) begin
            aux_addr <= (aux_addr == CW'(IMG_W - 2)) ? '0 : aux_addr + CW'(1);
        end
    end

    cfa_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(CW)) u_lb0 (
        .clk(clk), .enable(acc), .addr(x_cur), .wdata(pix_in), .rdata(rd[0])
    );

    for (genvar k = 1; k < 4; k++) begin : g_lb
        cfa_line_buffer #(.DEPTH(IMG_W - 1), .PIX_W(PIX_W), .AW(CW)) u_lb (
            .clk(clk), .enable(acc), .addr(aux_addr), .wdata(rd[k-1]), .rdata(rd[k])
        );
    end

    assign col_vec = {rd[3], rd[2], rd[1], rd[0], pix_q};
    assign h_vec   = {hsh[3], hsh[2], hsh[1], hsh[0], rd[1]};

    // Accept-advanced registers: pixel matching the buffer read, column delay, row r-2 history.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
            col_a <= '0;
            col_b <= '0;
            hsh   <= '0;
        end else if (acc) begin
            pix_q <= pix_in;
            col_a <= col_vec;
            col_b <= col_a;
            hsh   <= {hsh[2:0], rd[1]};
        end
    end

    // Per-cycle pipeline: qualify/coords, tap capture, output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_cr     <= '0;
            s1_cc     <= '0;
            s2_valid  <= 1'b0;
            s2_cr     <= '0;
            s2_cc     <= '0;
            s2_v      <= '0;
            s2_h      <= '0;
            out_valid <= 1'b0;
            cen_row   <= '0;
            cen_col   <= '0;
            cen_phase <= '0;
            out_v     <= '0;
            out_h     <= '0;
        end else begin
            s1_valid  <= qual;
            s1_cr     <= r_cur - RW'(2);
            s1_cc     <= x_cur - CW'(2);
            s2_valid  <= s1_valid;
            s2_cr     <= s1_cr;
            s2_cc     <= s1_cc;
            s2_v      <= col_b;
            s2_h      <= h_vec;
            out_valid <= s2_valid;
            cen_row   <= s2_cr;
            cen_col   <= s2_cc;
            cen_phase <= {s2_cr[0], s2_cc[0]};
            out_v     <= s2_v;
            out_h     <= s2_h;
        end
    end

    assign {v_m2, v_m1, v_c, v_p1, v_p2} = out_v;
    assign {h_m2, h_m1, h_c, h_p1, h_p2} = out_h;

endmodule

// File: tb/tb_cfa_tap_window.sv
// Scoreboard bench for cfa_tap_window on an 8x6 frame.
module tb_cfa_tap_window;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst, pix_valid, sof;
    logic [PW-1:0] pix_in;
    logic [PW-1:0] v_m2, v_m1, v_c, v_p1, v_p2, h_m2, h_m1, h_c, h_p1, h_p2;
    logic          out_valid;
    logic [2:0]    cen_row, cen_col;
    logic [1:0]    cen_phase;

    cfa_tap_window #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .v_m2(v_m2), .v_m1(v_m1), .v_c(v_c), .v_p1(v_p1), .v_p2(v_p2),
        .h_m2(h_m2), .h_m1(h_m1), .h_c(h_c), .h_p1(h_p1), .h_p2(h_p2),
        .out_valid(out_valid), .cen_row(cen_row), .cen_col(cen_col), .cen_phase(cen_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   due;
        int                   cr;
        int                   cc;
        logic [4:0][PW-1:0]   v;
        logic [4:0][PW-1:0]   h;
    } exp_t;

    exp_t          q[$];
    int            checks = 0, failures = 0, E = 0, pulses = 0;
    logic [PW-1:0] frame [H][W];
    int            n = 0;
    bit            active = 0;
    int            mr, mx;
    exp_t          me, pe;
    bit            grab = 0;
    int            g_E, g_cr, g_cc, acc44;
    logic [1:0]    g_phase;
    logic [4:0][PW-1:0] g_v, g_h, want;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: keep the current frame as a 2-D picture and emit the
    // expected neighbourhood for every interior centre at accept time + 2.
    always @(posedge clk) begin
        E = E + 1;
        if (rst) begin
            q.delete();
            active = 0;
        end else if (pix_valid) begin
            if (sof) begin
                active = 1;
                n = 0;
            end
            if (active) begin
                mr = n / W;
                mx = n % W;
                frame[mr][mx] = pix_in;
                if (mr >= 4 && mx >= 4) begin
                    me.due = E + 2;
                    me.cr  = mr - 2;
                    me.cc  = mx - 2;
                    for (int i = 0; i < 5; i++) begin
                        me.v[4-i] = frame[mr-4+i][mx-2];
                        me.h[4-i] = frame[mr-2][mx-4+i];
                    end
                    q.push_back(me);
                end
                n++;
                if (n == W * H) active = 0;
            end
        end
    end

    // Monitor: compares each presented output against the oldest expectation.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due < E) begin
            checks++;
            failures++;
            $display("FAIL missed_pulse actual=none expected=cr%0d_cc%0d_at%0d", q[0].cr, q[0].cc, q[0].due);
            void'(q.pop_front());
        end
        if (out_valid) begin
            pulses++;
            if (grab) begin
                grab    = 0;
                g_E     = E;
                g_cr    = int'(cen_row);
                g_cc    = int'(cen_col);
                g_phase = cen_phase;
                g_v     = {v_m2, v_m1, v_c, v_p1, v_p2};
                g_h     = {h_m2, h_m1, h_c, h_p1, h_p2};
            end
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=cr%0d_cc%0d expected=no_pulse", cen_row, cen_col);
            end else begin
                pe = q.pop_front();
                chk("pulse_time", 64'(E), 64'(pe.due));
                chk("cen_row", 64'(cen_row), 64'(pe.cr));
                chk("cen_col", 64'(cen_col), 64'(pe.cc));
                chk("cen_phase", 64'(cen_phase), 64'({pe.cr[0], pe.cc[0]}));
                chk("v_taps", 64'({v_m2, v_m1, v_c, v_p1, v_p2}), 64'(pe.v));
                chk("h_taps", 64'({h_m2, h_m1, h_c, h_p1, h_p2}), 64'(pe.h));
            end
        end
    end

    task automatic idle(input int k);
        pix_valid = 0;
        sof = 0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [PW-1:0] v, input bit s, input int duty);
        while ($urandom_range(99) >= duty) idle(1);
        pix_in = v;
        sof = s;
        pix_valid = 1;
        @(posedge clk);
        #1;
        pix_valid = 0;
        sof = 0;
    endtask

    // Sends pixels first..last (linear index) of a frame, sof on index 0.
    task automatic send_range(input int first, input int last, input int duty, input bit rnd);
        for (int i = first; i <= last; i++) begin
            put(rnd ? PW'($urandom_range(4095)) : PW'(16 * (i / W) + (i % W)), i == 0, duty);
            if (i == 4 * W + 4) acc44 = E;
        end
    endtask

    task automatic expect_pulses(input string nm, input int base, input int cnt);
        idle(6);
        chk(nm, 64'(pulses - base), 64'(cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1;
        pix_valid = 0;
        sof = 0;
        pix_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_cen_row", 64'(cen_row), 64'(0));
        chk("reset_cen_col", 64'(cen_col), 64'(0));
        chk("reset_cen_phase", 64'(cen_phase), 64'(0));
        chk("reset_v", 64'({v_m2, v_m1, v_c, v_p1, v_p2}), 64'(0));
        chk("reset_h", 64'({h_m2, h_m1, h_c, h_p1, h_p2}), 64'(0));

        // Pixels before any sof are ignored.
        base = pulses;
        for (int i = 0; i < 2 * W * H; i++) put(PW'($urandom_range(4095)), 0, 100);
        expect_pulses("no_sof_pulses", base, 0);

        // Clean continuous frame with directed first-pulse values.
        base = pulses;
        grab = 1;
        send_range(0, W * H - 1, 100, 0);
        expect_pulses("full_frame_pulses", base, 8);
        want = {12'd2, 12'd18, 12'd34, 12'd50, 12'd66};
        chk("first_v", 64'(g_v), 64'(want));
        want = {12'd32, 12'd33, 12'd34, 12'd35, 12'd36};
        chk("first_h", 64'(g_h), 64'(want));
        chk("first_phase", 64'(g_phase), 64'(0));
        chk("first_cr", 64'(g_cr), 64'(2));
        chk("first_cc", 64'(g_cc), 64'(2));
        chk("first_latency", 64'(g_E), 64'(acc44 + 2));

        // Same frame with ~40% valid duty.
        base = pulses;
        send_range(0, W * H - 1, 40, 0);
        expect_pulses("gap_frame_pulses", base, 8);

        // sof arrives at pixel (3,5): that pixel starts a clean new frame.
        base = pulses;
        send_range(0, 3 * W + 4, 100, 0);
        send_range(0, W * H - 1, 100, 0);
        expect_pulses("sof_mid_pulses", base, 8);

        // One-cycle reset during row 4, just after accepts (4,4) and (4,5).
        base = pulses;
        send_range(0, 4 * W + 5, 100, 0);
        rst = 1;
        pix_in = 12'hABC;
        pix_valid = 1;
        @(posedge clk);
        #1;
        rst = 0;
        pix_valid = 0;
        for (int i = 0; i < W * H; i++) put(PW'($urandom_range(4095)), 0, 100);
        expect_pulses("rst_mid_pulses", base, 0);
        base = pulses;
        send_range(0, W * H - 1, 60, 1);
        expect_pulses("after_rst_pulses", base, 8);

        // sof on the last pixel of a frame restarts instead of finishing.
        base = pulses;
        send_range(0, W * H - 2, 50, 1);
        put(PW'($urandom_range(4095)), 1, 100);
        send_range(1, W * H - 1, 50, 1);
        expect_pulses("last_sof_pulses", base, 15);

        // Random-content frames with random gap density.
        for (int f = 0; f < 3; f++) begin
            base = pulses;
            send_range(0, W * H - 1, int'($urandom_range(90, 30)), 1);
            expect_pulses("rand_frame_pulses", base, 8);
        end

        idle(6);
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
